// File: rtl/coh_defs.sv
// Shared encodings for the snooping-coherence instruction path.
package coh_defs;

  typedef enum logic [1:0] {
    PROC_P0   = 2'b00,
    PROC_P1   = 2'b01,
    PROC_P2   = 2'b10,
    PROC_NONE = 2'b11
  } proc_e;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_HALT
  } state_e;

  localparam logic [1:0] IDLE_OPCODE = '1;
  localparam logic [3:0] IDLE_TAG    = '1;
  localparam logic [7:0] IDLE_DATA   = '1;

  function automatic logic op_legal(input logic [1:0] op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

endpackage

// File: rtl/inst_dispatch.sv
// Pulls instructions one at a time, issues them to P0/P1/P2 and waits for the
// target's done; flags illegal opcodes, timeouts and end-of-program.
module inst_dispatch
  import coh_defs::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [1:0]       proc,
  input  logic [1:0]       opcode,
  input  logic [3:0]       tag,
  input  logic [7:0]       data,
  input  logic             done_p0,
  input  logic             done_p1,
  input  logic             done_p2,
  output logic             send,
  output logic [2:0]       start,
  output logic [1:0]       cpu_opcode,
  output logic [3:0]       cpu_tag,
  output logic [7:0]       cpu_data,
  output logic             busy,
  output logic             halted,
  output logic             err_opcode,
  output logic             err_timeout,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

  state_e            r_state;
  state_e            w_next;
  proc_e             r_target;
  logic [WCNT_W-1:0] r_wcnt;
  logic              w_done;
  logic              w_last;
  logic              w_legal;

  // Only the latched target's done line is ever observed.
  always_comb begin
    w_done = 1'b0;
    unique case (r_target)
      PROC_P0: w_done = done_p0;
      PROC_P1: w_done = done_p1;
      PROC_P2: w_done = done_p2;
      default: w_done = 1'b0;
    endcase
  end

  assign w_last  = (r_wcnt == WCNT_LAST);
  assign w_legal = op_legal(opcode);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (run) w_next = S_REQ;
      S_REQ:   w_next = S_FETCH;
      S_FETCH: begin
        if (proc == PROC_NONE) w_next = S_HALT;
        else if (!w_legal)     w_next = S_REQ;
        else                   w_next = S_ISSUE;
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_done || w_last) w_next = run ? S_REQ : S_IDLE;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    send   = (r_state == S_REQ);
    busy   = (r_state != S_IDLE) && (r_state != S_HALT);
    halted = (r_state == S_HALT);
    start  = '0;
    if (r_state == S_ISSUE) begin
      unique case (r_target)
        PROC_P0: start = 3'b001;
        PROC_P1: start = 3'b010;
        PROC_P2: start = 3'b100;
        default: start = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cpu_opcode <= IDLE_OPCODE;
      cpu_tag    <= IDLE_TAG;
      cpu_data   <= IDLE_DATA;
      r_target   <= PROC_NONE;
    end else if (r_state == S_FETCH && w_next == S_ISSUE) begin
      cpu_opcode <= opcode;
      cpu_tag    <= tag;
      cpu_data   <= data;
      r_target   <= proc_e'(proc);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wcnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_wcnt <= '0;
    end else if (r_state == S_WAIT && !w_last) begin
      r_wcnt <= r_wcnt + WCNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_opcode  <= 1'b0;
      err_timeout <= 1'b0;
      retired     <= '0;
    end else begin
      if (r_state == S_FETCH && proc != PROC_NONE && !w_legal)
        err_opcode <= 1'b1;
      if (r_state == S_WAIT) begin
        if (w_done)      retired     <= retired + CNT_W'(1);
        else if (w_last) err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_dispatch.sv
// Randomised scoreboard bench for inst_dispatch with a behavioural
// instruction-memory / processor model.
module tb_inst_dispatch;

  localparam int TO = 8;

  typedef struct {
    logic [1:0] p;
    logic [1:0] op;
    logic [3:0] tag;
    logic [7:0] data;
    int         delay;
    bit         drop_run;
    bit         issue_noise;
  } instr_t;

  typedef struct {
    logic [2:0] start;
    logic [1:0] op;
    logic [3:0] tag;
    logic [7:0] data;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       run   = 1'b0;
  logic [1:0] proc  = 2'b11;
  logic [1:0] opcode = 2'b00;
  logic [3:0] tag   = 4'h0;
  logic [7:0] data  = 8'h00;
  logic [2:0] done_v = 3'b000;
  logic       send;
  logic [2:0] start;
  logic [1:0] cpu_opcode;
  logic [3:0] cpu_tag;
  logic [7:0] cpu_data;
  logic       busy, halted, err_opcode, err_timeout;
  logic [7:0] retired;

  instr_t prog[$];
  instr_t pend[$];
  exp_t   sb[$];
  int     total = 0;
  int     bad   = 0;
  int     exp_ret = 0;
  bit     exp_eop = 0;
  bit     exp_eto = 0;

  always #5 clock = ~clock;

  inst_dispatch #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .run(run),
    .proc(proc), .opcode(opcode), .tag(tag), .data(data),
    .done_p0(done_v[0]), .done_p1(done_v[1]), .done_p2(done_v[2]),
    .send(send), .start(start),
    .cpu_opcode(cpu_opcode), .cpu_tag(cpu_tag), .cpu_data(cpu_data),
    .busy(busy), .halted(halted), .err_opcode(err_opcode),
    .err_timeout(err_timeout), .retired(retired)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_send"}, send, 0);
    chk({pfx, "_start"}, start, 0);
    chk({pfx, "_cpu_op"}, cpu_opcode, 2'b11);
    chk({pfx, "_cpu_tag"}, cpu_tag, 4'hF);
    chk({pfx, "_cpu_data"}, cpu_data, 8'hFF);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_halted"}, halted, 0);
    chk({pfx, "_err_op"}, err_opcode, 0);
    chk({pfx, "_err_to"}, err_timeout, 0);
    chk({pfx, "_retired"}, retired, 0);
  endtask

  function automatic instr_t mk(input logic [1:0] p, input logic [1:0] op,
                                input logic [3:0] t, input logic [7:0] d,
                                input int dly, input bit dr, input bit nz);
    instr_t i;
    i.p = p; i.op = op; i.tag = t; i.data = d;
    i.delay = dly; i.drop_run = dr; i.issue_noise = nz;
    return i;
  endfunction

  function automatic instr_t rnd_instr();
    logic [1:0] op;
    op = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
    return mk(2'($urandom_range(0, 2)), op, 4'($urandom), 8'($urandom),
              ($urandom_range(0, 5) == 0) ? $urandom_range(TO - 2, TO + 3) : $urandom_range(0, 4),
              $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1);
  endfunction

  // Instruction memory: answers each send with the next program entry.
  always @(negedge clock) begin
    if (reset === 1'b1 && send === 1'b1) begin
      instr_t it;
      exp_t e;
      if (prog.size() > 0) it = prog.pop_front();
      else it = mk(2'b11, 2'b00, 4'h0, 8'h00, 0, 0, 0);
      proc = it.p; opcode = it.op; tag = it.tag; data = it.data;
      if (it.p != 2'b11) begin
        if (it.op[1]) exp_eop = 1;
        else begin
          e.start = 3'b001 << it.p;
          e.op = it.op; e.tag = it.tag; e.data = it.data;
          sb.push_back(e);
          pend.push_back(it);
        end
      end
    end
  end

  // Monitor: every issue pulse must match the oldest expected issue.
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      if (send === 1'b1 && start !== 3'b000) chk("send_start_overlap", {send, start}, {1'b0, 3'b000});
      if (start !== 3'b000) begin
        if (sb.size() == 0) chk("start_unexpected", start, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("start", start, e.start);
          chk("cpu_opcode", cpu_opcode, e.op);
          chk("cpu_tag", cpu_tag, e.tag);
          chk("cpu_data", cpu_data, e.data);
        end
      end
    end
  end

  task automatic handle(input instr_t it);
    int exit_w;
    bit retire;
    exit_w = (it.delay < TO) ? it.delay : TO - 1;
    retire = (it.delay < TO);
    done_v = 3'($urandom) & ~(3'b001 << it.p);
    if (it.issue_noise) done_v[it.p] = 1'b1;
    for (int w = 0; w <= exit_w; w++) begin
      @(negedge clock);
      if (reset !== 1'b1) begin
        done_v = 3'b000;
        return;
      end
      done_v = 3'($urandom) & ~(3'b001 << it.p);
      done_v[it.p] = (w == it.delay);
      chk("busy_wait", busy, 1);
    end
    if (it.drop_run) run = 1'b0;
    @(negedge clock);
    done_v = 3'b000;
    if (reset !== 1'b1) return;
    if (retire) begin
      exp_ret++;
      chk("retired", retired, exp_ret & 8'hFF);
    end else begin
      exp_eto = 1;
      chk("err_timeout", err_timeout, 1);
      chk("retired_after_to", retired, exp_ret & 8'hFF);
    end
    if (it.drop_run) begin
      chk("idle_busy", busy, 0);
      for (int k = 0; k < 3; k++) begin
        @(negedge clock);
        chk("idle_send", send, 0);
      end
      run = 1'b1;
    end
  endtask

  // Processor model: raises the target's done after the chosen delay.
  initial begin
    forever begin
      @(negedge clock);
      if (reset === 1'b1 && start !== 3'b000 && pend.size() > 0) begin
        instr_t it;
        it = pend.pop_front();
        handle(it);
      end
    end
  end

  task automatic wait_halt_and_check(input string pfx);
    int n;
    int sends;
    n = 0;
    while (halted !== 1'b1 && n < 5000) begin
      @(negedge clock);
      n++;
    end
    chk({pfx, "_halted"}, halted, 1);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_err_op"}, err_opcode, exp_eop);
    chk({pfx, "_err_to"}, err_timeout, exp_eto);
    chk({pfx, "_retired"}, retired, exp_ret & 8'hFF);
    chk({pfx, "_sb_left"}, sb.size(), 0);
    sends = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (send === 1'b1 || start !== 3'b000) sends++;
    end
    chk({pfx, "_quiet_after_halt"}, sends, 0);
  endtask

  task automatic restart();
    prog.delete(); pend.delete(); sb.delete();
    exp_ret = 0; exp_eop = 0; exp_eto = 0;
    done_v = 3'b000;
  endtask

  initial begin
    int n;
    reset = 1'b0;
    run = 1'b0;
    repeat (2) @(negedge clock);
    chk_reset_vals("rst0");
    reset = 1'b1;

    prog.push_back(mk(2'b01, 2'b00, 4'hA, 8'h00, 0, 0, 0));
    prog.push_back(mk(2'b00, 2'b01, 4'hA, 8'h07, 2, 0, 1));
    prog.push_back(mk(2'b10, 2'b10, 4'h3, 8'h55, 0, 0, 0));
    prog.push_back(mk(2'b00, 2'b00, 4'h5, 8'h00, TO + 2, 0, 0));
    prog.push_back(mk(2'b10, 2'b01, 4'hC, 8'h99, TO - 1, 1, 1));
    for (int i = 0; i < 40; i++) prog.push_back(rnd_instr());
    prog.push_back(mk(2'b11, 2'b00, 4'h0, 8'h00, 0, 0, 0));
    @(negedge clock);
    run = 1'b1;
    wait_halt_and_check("prog1");

    reset = 1'b0;
    #1;
    restart();
    chk_reset_vals("rst_after_halt");
    @(negedge clock);
    reset = 1'b1;
    prog.push_back(mk(2'b10, 2'b01, 4'h6, 8'h42, 1000, 0, 0));
    n = 0;
    while (start === 3'b000 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("mid_issue_seen", start, 3'b100);
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    #1 chk_reset_vals("rst_mid_wait");
    @(negedge clock);
    restart();
    run = 1'b1;
    @(negedge clock);
    chk_reset_vals("rst_hold");
    reset = 1'b1;
    for (int i = 0; i < 25; i++) prog.push_back(rnd_instr());
    prog.push_back(mk(2'b11, 2'b00, 4'h0, 8'h00, 0, 0, 0));
    wait_halt_and_check("prog2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
